// File: rtl/layer_sequencer.sv
// layer_sequencer: launches N_LAYERS layer blocks in a fixed order, multiplexes the
// active layer onto the shared feature-map RAM and flags a layer that never ends.
module layer_sequencer #(
    parameter int          N_LAYERS  = 4,
    parameter int          START_LEN = 2,
    parameter int          GAP_CYC   = 4,
    parameter logic [23:0] TIMEOUT   = 24'd2000000,
    parameter int          ADDR_W    = 16,
    parameter int          DATA_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [2:0]                 err_layer,
    output logic [2:0]                 cur_layer,
    output logic [N_LAYERS-1:0]        start_o,
    input  logic [N_LAYERS-1:0]        end_i,
    input  logic [N_LAYERS*ADDR_W-1:0] lay_addr_w,
    input  logic [N_LAYERS*DATA_W-1:0] lay_data_w,
    input  logic [N_LAYERS-1:0]        lay_en,
    input  logic [N_LAYERS-1:0]        lay_wea,
    input  logic [N_LAYERS*ADDR_W-1:0] lay_addr_r,
    input  logic [N_LAYERS-1:0]        lay_en_r,
    output logic [ADDR_W-1:0]          ram_addr_w,
    output logic [DATA_W-1:0]          ram_data_w,
    output logic                       ram_en,
    output logic                       ram_wea,
    output logic [ADDR_W-1:0]          ram_addr_r,
    output logic                       ram_en_r
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cur_q, cur_d;
    logic [2:0]          err_layer_q, err_layer_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [7:0]          start_cnt_q, start_cnt_d;
    logic [7:0]          gap_cnt_q, gap_cnt_d;
    logic [23:0]         wdog_q, wdog_d, wdog_inc_s;
    logic [N_LAYERS-1:0] end_prev_q;
    logic                end_cur_s, end_prev_cur_s, end_rise_s, mux_on_s;
    logic [ADDR_W-1:0]   sel_addr_w_s, sel_addr_r_s;
    logic [DATA_W-1:0]   sel_data_w_s;
    logic                sel_en_s, sel_wea_s, sel_en_r_s;

    // State, counter and end-edge registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_q       <= 3'd0;
            err_layer_q <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            start_cnt_q <= 8'd0;
            gap_cnt_q   <= 8'd0;
            wdog_q      <= 24'd0;
            end_prev_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            err_layer_q <= err_layer_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            start_cnt_q <= start_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            wdog_q      <= wdog_d;
            end_prev_q  <= end_i;
        end
    end

    // Select the current layer's end flag and RAM port slices
    always_comb begin
        end_cur_s      = 1'b0;
        end_prev_cur_s = 1'b0;
        sel_addr_w_s   = '0;
        sel_data_w_s   = '0;
        sel_en_s       = 1'b0;
        sel_wea_s      = 1'b0;
        sel_addr_r_s   = '0;
        sel_en_r_s     = 1'b0;
        for (int k = 0; k < N_LAYERS; k++) begin
            if (cur_q == 3'(k)) begin
                end_cur_s      = end_i[k];
                end_prev_cur_s = end_prev_q[k];
                sel_addr_w_s   = lay_addr_w[k*ADDR_W +: ADDR_W];
                sel_data_w_s   = lay_data_w[k*DATA_W +: DATA_W];
                sel_en_s       = lay_en[k];
                sel_wea_s      = lay_wea[k];
                sel_addr_r_s   = lay_addr_r[k*ADDR_W +: ADDR_W];
                sel_en_r_s     = lay_en_r[k];
            end else begin
                end_cur_s = end_cur_s;
            end
        end
    end

    // Only a 0->1 transition counts, so a stale high level never ends a wait
    assign end_rise_s = end_cur_s & ~end_prev_cur_s;
    assign wdog_inc_s = (wdog_q == TIMEOUT - 24'd1) ? wdog_q : wdog_q + 24'd1;

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        err_layer_d = err_layer_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        start_cnt_d = start_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        wdog_d      = wdog_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_d     = S_LAUNCH;
                    cur_d       = 3'd0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    start_cnt_d = 8'd0;
                    wdog_d      = 24'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LAUNCH: begin
                wdog_d = wdog_inc_s;
                if (start_cnt_q == 8'(START_LEN - 1)) begin
                    state_d     = S_WAIT;
                    start_cnt_d = 8'd0;
                end else begin
                    start_cnt_d = start_cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                wdog_d = wdog_inc_s;
                if (end_rise_s) begin
                    state_d   = S_GAP;
                    gap_cnt_d = 8'd0;
                end else if (wdog_q == TIMEOUT - 24'd1) begin
                    state_d     = S_ERR;
                    err_layer_d = cur_q;
                    err_d       = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 8'(GAP_CYC - 1)) begin
                    gap_cnt_d = 8'd0;
                    if (cur_q == 3'(N_LAYERS - 1)) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = S_LAUNCH;
                        cur_d       = cur_q + 3'd1;
                        start_cnt_d = 8'd0;
                        wdog_d      = 24'd0;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The mux stays on through GAP so a layer's trailing writes still land
    assign mux_on_s = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_GAP);

    // Start strobe and RAM port outputs
    always_comb begin
        start_o    = '0;
        ram_addr_w = '0;
        ram_data_w = '0;
        ram_en     = 1'b0;
        ram_wea    = 1'b0;
        ram_addr_r = '0;
        ram_en_r   = 1'b0;
        for (int k = 0; k < N_LAYERS; k++) begin
            if ((state_q == S_LAUNCH) && (cur_q == 3'(k))) begin
                start_o[k] = 1'b1;
            end else begin
                start_o[k] = 1'b0;
            end
        end
        if (mux_on_s) begin
            ram_addr_w = sel_addr_w_s;
            ram_data_w = sel_data_w_s;
            ram_en     = sel_en_s;
            ram_wea    = sel_wea_s;
            ram_addr_r = sel_addr_r_s;
            ram_en_r   = sel_en_r_s;
        end else begin
            ram_en = 1'b0;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_layer = err_layer_q;
    assign cur_layer = cur_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer: behavioural layers, a timeline reference
// model and an event scoreboard for launches, completion and timeouts.
module tb_layer_sequencer;
    localparam int N   = 4;
    localparam int SL  = 2;
    localparam int GAP = 4;
    localparam int TO  = 500;
    localparam int AW  = 16;
    localparam int DW  = 8;

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         err;
        logic [2:0]   errl;
        logic [2:0]   cur;
        logic [N-1:0] start;
    } obs_t;

    typedef struct {
        int kind;   // 0 launch, 1 done, 2 err
        int layer;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst, go;
    logic busy, done, err;
    logic [2:0] err_layer, cur_layer;
    logic [N-1:0] start_o, end_i;
    logic [N*AW-1:0] lay_addr_w, lay_addr_r;
    logic [N*DW-1:0] lay_data_w;
    logic [N-1:0] lay_en, lay_wea, lay_en_r;
    logic [AW-1:0] ram_addr_w, ram_addr_r;
    logic [DW-1:0] ram_data_w;
    logic ram_en, ram_wea, ram_en_r;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit pat_on = 1'b0;
    bit fin_req = 1'b0;
    int l_delay[N];
    bit l_stale[N];
    int l_stale_from = 0;

    // reference model of the current run
    bit   m_valid = 1'b0;
    int   m_go = 0;
    int   m_rst = -1;
    int   m_delay[N];
    obs_t m_base = '0;
    ev_t  exp_q[$];

    layer_sequencer #(
        .N_LAYERS(N), .START_LEN(SL), .GAP_CYC(GAP), .TIMEOUT(24'(TO)),
        .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done), .err(err),
        .err_layer(err_layer), .cur_layer(cur_layer), .start_o(start_o), .end_i(end_i),
        .lay_addr_w(lay_addr_w), .lay_data_w(lay_data_w), .lay_en(lay_en), .lay_wea(lay_wea),
        .lay_addr_r(lay_addr_r), .lay_en_r(lay_en_r),
        .ram_addr_w(ram_addr_w), .ram_data_w(ram_data_w), .ram_en(ram_en), .ram_wea(ram_wea),
        .ram_addr_r(ram_addr_r), .ram_en_r(ram_en_r)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected observable outputs at cycle c, from the run's arithmetic schedule
    function automatic void model_at(input int c, output obs_t o, output int sel);
        int t;
        o = m_base;
        sel = -1;
        if (!m_valid || c <= m_go) return;
        if (m_rst >= 0 && c > m_rst) begin
            o = '0;
            return;
        end
        o.busy = 1'b1; o.done = 1'b0; o.err = 1'b0; o.start = '0;
        t = m_go + 1;
        for (int k = 0; k < N; k++) begin
            o.cur = 3'(k);
            sel = k;
            if (c < t + SL) o.start[k] = 1'b1;
            if (m_delay[k] == 0) begin
                if (c < t + TO) return;
                o.busy = 1'b0; o.err = 1'b1; o.errl = 3'(k); sel = -1;
                return;
            end
            if (c <= t + m_delay[k] + GAP) return;
            t = t + m_delay[k] + 1 + GAP;
        end
        o.busy = 1'b0; o.done = 1'b1; o.cur = 3'(N - 1); sel = -1;
    endfunction

    // Behavioural layers: end rises delay cycles after start, held 3 cycles
    initial begin
        int st[N];
        bit e;
        bit pstart[N];
        for (int k = 0; k < N; k++) begin st[k] = -100000; pstart[k] = 1'b0; end
        end_i = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (start_o[k] && !pstart[k]) st[k] = cyc;
                pstart[k] = start_o[k];
                e = 1'b0;
                if (l_stale[k] && (st[k] < l_stale_from || cyc < st[k] + 10)) e = 1'b1;
                if (l_delay[k] > 0 && cyc >= st[k] + l_delay[k] && cyc <= st[k] + l_delay[k] + 2) e = 1'b1;
                end_i[k] = e;
            end
        end
    end

    // Random RAM-port traffic from every layer
    initial begin
        lay_addr_w = '0; lay_data_w = '0; lay_en = '0; lay_wea = '0; lay_addr_r = '0; lay_en_r = '0;
        forever begin
            @(posedge clk); #1;
            lay_addr_w = {$urandom, $urandom};
            lay_addr_r = {$urandom, $urandom};
            lay_data_w = $urandom;
            lay_en     = 4'($urandom);
            lay_wea    = 4'($urandom);
            lay_en_r   = 4'($urandom);
            if (pat_on) begin
                lay_addr_w[2*AW +: AW] = 16'h28AD;
                lay_data_w[2*DW +: DW] = 8'h5A;
                lay_en[2] = 1'b1; lay_wea[2] = 1'b1;
                lay_en[0] = 1'b1; lay_wea[0] = 1'b1;
            end
        end
    end

    task automatic check_ev(input int kind, input int lay);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: unexpected kind=%0d layer=%0d at cyc=%0d", kind, lay, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.layer != lay || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL event: got kind=%0d layer=%0d cyc=%0d, exp kind=%0d layer=%0d cyc=%0d",
                         kind, lay, cyc, e.kind, e.layer, e.cyc);
            end
        end
    endtask

    // Monitor: per-cycle timeline check plus event scoreboard
    obs_t eo, ao;
    int   es, lay;
    logic [41:0] er, ar;
    logic [N-1:0] prev_start = '0;
    logic prev_done = 1'b0, prev_err = 1'b0;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            model_at(cyc, eo, es);
            ao = {busy, done, err, err_layer, cur_layer, start_o};
            n_chk++;
            if (ao !== eo) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d got busy/done/err/errl/cur/start=%b exp=%b", cyc, ao, eo);
            end
            er = '0;
            if (es >= 0)
                er = {lay_addr_w[es*AW +: AW], lay_data_w[es*DW +: DW], lay_en[es], lay_wea[es],
                      lay_addr_r[es*AW +: AW], lay_en_r[es]};
            ar = {ram_addr_w, ram_data_w, ram_en, ram_wea, ram_addr_r, ram_en_r};
            n_chk++;
            if (ar !== er) begin
                n_fail++;
                $display("FAIL ram_mux cyc=%0d got=%h exp=%h (layer %0d)", cyc, ar, er, es);
            end
            if (start_o != '0 && prev_start == '0) begin
                lay = -1;
                for (int k = 0; k < N; k++) if (start_o[k]) lay = k;
                check_ev(0, lay);
            end
            if (done && !prev_done) check_ev(1, int'(cur_layer));
            if (err && !prev_err) check_ev(2, int'(err_layer));
            prev_start = start_o; prev_done = done; prev_err = err;
        end
        if (fin_req) begin
            fin_req = 1'b0;
            n_chk++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL scoreboard_drain: got %0d events pending, exp 0", exp_q.size());
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Pulse go; when accepted, load the model and push expected events
    task automatic do_go(input bit accepted);
        obs_t b;
        int s, t;
        ev_t e;
        @(posedge clk); #1;
        go = 1'b1;
        if (accepted) begin
            model_at(cyc, b, s);
            m_base = b;
            m_go = cyc; m_rst = -1; m_valid = 1'b1;
            for (int k = 0; k < N; k++) m_delay[k] = l_delay[k];
            t = cyc + 1;
            for (int k = 0; k < N; k++) begin
                e.kind = 0; e.layer = k; e.cyc = t; exp_q.push_back(e);
                if (l_delay[k] == 0) begin
                    e.kind = 2; e.layer = k; e.cyc = t + TO; exp_q.push_back(e);
                    break;
                end
                t = t + l_delay[k] + 1 + GAP;
                if (k == N - 1) begin
                    e.kind = 1; e.layer = N - 1; e.cyc = t; exp_q.push_back(e);
                end
            end
        end
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        m_rst = cyc;
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].cyc > cyc) exp_q.delete(i);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic int run_len();
        int s = 0;
        for (int k = 0; k < N; k++) s += l_delay[k] + 1 + GAP;
        return s;
    endfunction

    initial begin
        rst = 1'b1; go = 1'b0;
        for (int k = 0; k < N; k++) begin l_delay[k] = 100; l_stale[k] = 1'b0; end
        wait_cyc(3); #1;
        rst = 1'b0;
        wait_cyc(3);

        // nominal run with the fixed mux pattern
        pat_on = 1'b1;
        do_go(1'b1);
        wait_cyc(run_len() + 5);

        // restart from DONE: stale end on layer 1, end edge on last watchdog cycle of layer 3
        pat_on = 1'b0;
        l_delay[0] = $urandom_range(2, 80);
        l_delay[1] = 30;
        l_delay[2] = $urandom_range(2, 80);
        l_delay[3] = TO - 1;
        l_stale[1] = 1'b1; l_stale_from = cyc;
        do_go(1'b1);
        wait_cyc(run_len() + 5);
        l_stale[1] = 1'b0;

        // timeout on layer 1, go ignored in ERR, reset clears it
        l_delay[0] = 100; l_delay[1] = 0;
        do_go(1'b1);
        wait_cyc(106 + TO + 10);
        do_go(1'b0);
        wait_cyc(5);
        pulse_rst();
        wait_cyc(5);

        // reset in the middle of layer 2's wait, then a fresh run
        for (int k = 0; k < N; k++) l_delay[k] = $urandom_range(2, 80);
        l_delay[2] = $urandom_range(30, 80);
        do_go(1'b1);
        wait_cyc(l_delay[0] + l_delay[1] + 18);
        pulse_rst();
        wait_cyc(3);

        // random runs, with a go while busy that must be ignored
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++) l_delay[k] = $urandom_range(2, 80);
            do_go(1'b1);
            wait_cyc(l_delay[0]);
            do_go(1'b0);
            wait_cyc(run_len() - l_delay[0] + 3);
        end

        wait_cyc(5);
        fin_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
